// File: rtl/axis_uart_pkg.sv
// axis_uart_pkg: types shared by the axis_uart receive path.
// The receiver's per-frame status word and FSM state encoding live here so the
// register block and the receiver agree on the tuser layout.
package axis_uart_pkg;

  // Per-frame status carried on m_axis_tuser, MSB first: {brk, frame_err, parity_err}
  typedef struct packed {
    logic brk;
    logic frame_err;
    logic parity_err;
  } uart_rx_user_t;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    STOP2,
    OUT,
    BREAK
  } uart_rx_state_e;

  // Expected parity bit for up to 9 data bits (unused upper bits must be 0).
  // odd = 1 gives odd parity (~^data), otherwise even parity (^data).
  function automatic logic parity(input logic [8:0] data, input logic odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: sample-tick generator for the oversampling receiver.
// A down-counter reloads with divider-1 and emits tick when it reaches 0.
// A divider of 0 behaves like 1 (tick every cycle). While restart_i is high the
// counter is held at its reload value and no tick is produced, so the first
// tick after restart falls a full divider period later.
module uart_baud_tick #(
  parameter int DIVIDER_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     restart_i,
  input  logic [DIVIDER_WIDTH-1:0] divider_i,
  output logic                     tick_o
);

  logic [DIVIDER_WIDTH-1:0] cnt_q;
  logic [DIVIDER_WIDTH-1:0] reload;

  assign reload = (divider_i == '0) ? '0 : divider_i - DIVIDER_WIDTH'(1);
  assign tick_o = ~restart_i & (cnt_q == '0);

  // Count down to zero, reload on wrap or on restart
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else if (restart_i || (cnt_q == '0)) begin
      cnt_q <= reload;
    end else begin
      cnt_q <= cnt_q - DIVIDER_WIDTH'(1);
    end
  end

endmodule

// File: rtl/axis_uart_rx_ovs.sv
// axis_uart_rx_ovs: oversampling UART receiver with an AXI-Stream master output.
// Each bit is decided by a majority vote of three samples around mid-bit; the
// start bit is re-checked so short low glitches are ignored. Frame status is
// reported on tuser as {brk, frame_err, parity_err}.
// Optional feature: define AXIS_UART_RX_BREAK_DETECT_EN to flag break frames
// on tuser[2] and hold off reception until the line has been high for a bit.
module axis_uart_rx_ovs
  import axis_uart_pkg::*;
#(
  parameter int DATA_WIDTH    = 8,
  parameter int OVERSAMPLE    = 16,
  parameter int DIVIDER_WIDTH = 16
) (
  input  logic                     clk_i,
  input  logic                     rstn_i,
  input  logic                     rx_i,
  input  logic [DIVIDER_WIDTH-1:0] clk_divider_i,
  input  logic                     parity_odd_i,
  input  logic                     parity_even_i,
  input  logic                     two_stop_i,
  output logic [DATA_WIDTH-1:0]    m_axis_tdata,
  output logic [2:0]               m_axis_tuser,
  output logic                     m_axis_tvalid,
  input  logic                     m_axis_tready,
  output logic                     overrun_o,
  output logic                     busy_o
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_WIDTH);
  localparam logic [CNT_W-1:0] S_LO   = CNT_W'(OVERSAMPLE / 2 - 1);
  localparam logic [CNT_W-1:0] S_MID  = CNT_W'(OVERSAMPLE / 2);
  localparam logic [CNT_W-1:0] S_HI   = CNT_W'(OVERSAMPLE / 2 + 1);
  localparam logic [CNT_W-1:0] S_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] B_LAST = BIT_W'(DATA_WIDTH - 1);

  uart_rx_state_e state_q, state_d;

  logic sync1_q, sync2_q, prev_q;
  logic rx_s, start_edge;

  logic [DIVIDER_WIDTH-1:0] div_q;
  logic                     par_en_q, par_odd_q, two_stop_q;

  logic                     tick;
  logic [CNT_W-1:0]         sample_cnt_q;
  logic                     s0_q, s1_q, vote, decide, last_stop;

  logic [BIT_W-1:0]         bit_cnt_q;
  logic [DATA_WIDTH-1:0]    data_q;
  logic                     pe_q, fe_q, brk_q, parity_exp;

  logic [DATA_WIDTH-1:0]    tdata_q;
  uart_rx_user_t            user_q;
  logic                     tvalid_q, overrun_q;

  assign rx_s       = sync2_q;
  assign start_edge = prev_q & ~sync2_q;
  assign vote       = (s0_q & s1_q) | (s0_q & rx_s) | (s1_q & rx_s);
  assign decide     = tick && (sample_cnt_q == S_HI);
  assign last_stop  = decide && (((state_q == STOP) && !two_stop_q) || (state_q == STOP2));
  assign parity_exp = par_odd_q ? ~^data_q : ^data_q;

  // Two-flop synchroniser plus one history flop for falling-edge detection
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= rx_i;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // In IDLE the tick counter tracks the live divider so it is already loaded
  // with the value latched at the start edge; mid-frame it uses the latch.
  uart_baud_tick #(
    .DIVIDER_WIDTH(DIVIDER_WIDTH)
  ) u_baud_tick (
    .clk_i     (clk_i),
    .rstn_i    (rstn_i),
    .restart_i (state_q == IDLE),
    .divider_i ((state_q == IDLE) ? clk_divider_i : div_q),
    .tick_o    (tick)
  );

  // Sample position within the bit; in BREAK it counts consecutive high ticks
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      sample_cnt_q <= '0;
    end else if ((state_q == IDLE) || (state_q == OUT)) begin
      sample_cnt_q <= '0;
    end else if (tick) begin
      if ((state_q == BREAK) && !rx_s) begin
        sample_cnt_q <= '0;
      end else if (sample_cnt_q == S_LAST) begin
        sample_cnt_q <= '0;
      end else begin
        sample_cnt_q <= sample_cnt_q + CNT_W'(1);
      end
    end
  end

  // Capture the two samples that precede the mid-bit decision
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      s0_q <= 1'b1;
      s1_q <= 1'b1;
    end else if (tick) begin
      if (sample_cnt_q == S_LO)  s0_q <= rx_s;
      if (sample_cnt_q == S_MID) s1_q <= rx_s;
    end
  end

  // Frame datapath: config latch at the start edge, shift, parity and stop checks
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      div_q      <= '0;
      par_en_q   <= 1'b0;
      par_odd_q  <= 1'b0;
      two_stop_q <= 1'b0;
      bit_cnt_q  <= '0;
      data_q     <= '0;
      pe_q       <= 1'b0;
      fe_q       <= 1'b0;
    end else if (state_q == IDLE) begin
      bit_cnt_q <= '0;
      pe_q      <= 1'b0;
      fe_q      <= 1'b0;
      if (start_edge) begin
        div_q      <= clk_divider_i;
        par_en_q   <= parity_odd_i | parity_even_i;
        par_odd_q  <= parity_odd_i;
        two_stop_q <= two_stop_i;
      end
    end else if (decide) begin
      case (state_q)
        DATA: begin
          data_q    <= {vote, data_q[DATA_WIDTH-1:1]};
          bit_cnt_q <= bit_cnt_q + BIT_W'(1);
        end
        PARITY:      pe_q <= (vote != parity_exp);
        STOP, STOP2: if (!vote) fe_q <= 1'b1;
        default: ;
      endcase
    end
  end

`ifdef AXIS_UART_RX_BREAK_DETECT_EN
  // Break: all-zero data, framing error and the line still low at the last stop decision
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      brk_q <= 1'b0;
    end else if (state_q == IDLE) begin
      brk_q <= 1'b0;
    end else if (last_stop) begin
      brk_q <= (data_q == '0) && (fe_q || !vote) && !rx_s;
    end
  end
`else
  assign brk_q = 1'b0;
`endif

  // State register
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; every bit transition happens at its mid-bit decision tick
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:   if (start_edge) state_d = START;
      START:  if (decide) state_d = vote ? IDLE : DATA;
      DATA:   if (decide && (bit_cnt_q == B_LAST)) state_d = par_en_q ? PARITY : STOP;
      PARITY: if (decide) state_d = STOP;
      STOP:   if (decide) state_d = two_stop_q ? STOP2 : OUT;
      STOP2:  if (decide) state_d = OUT;
`ifdef AXIS_UART_RX_BREAK_DETECT_EN
      OUT:    state_d = brk_q ? BREAK : IDLE;
      BREAK:  if (tick && rx_s && (sample_cnt_q == S_LAST)) state_d = IDLE;
`else
      OUT:    state_d = IDLE;
`endif
      default: state_d = IDLE;
    endcase
  end

  // Single-entry output register; a frame arriving while a word is stalled is dropped
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      tdata_q   <= '0;
      user_q    <= '0;
      tvalid_q  <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= 1'b0;
      if (state_q == OUT) begin
        if (tvalid_q && !m_axis_tready) begin
          overrun_q <= 1'b1;
        end else begin
          tdata_q  <= data_q;
          user_q   <= {brk_q, fe_q, pe_q};
          tvalid_q <= 1'b1;
        end
      end else if (tvalid_q && m_axis_tready) begin
        tvalid_q <= 1'b0;
      end
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tuser  = user_q;
  assign m_axis_tvalid = tvalid_q;
  assign overrun_o     = overrun_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_axis_uart_rx_ovs.sv
// tb_axis_uart_rx_ovs: directed bench for the oversampling UART receiver.
// An 8-bit and a 7-bit instance each get their own serial line; frames are
// driven cycle by cycle and outputs are observed 1 ns after each rising edge.
module tb_axis_uart_rx_ovs;

  localparam int BIT_CLKS = 64;  // divider 4 x oversample 16

  logic        clk = 1'b0;
  logic        rstn;
  logic        rx8, rx7;
  logic [15:0] clk_div;
  logic        par_odd, par_even, two_stop;
  logic        tready8, tready7;
  logic [7:0]  tdata8;
  logic [6:0]  tdata7;
  logic [2:0]  tuser8, tuser7;
  logic        tvalid8, tvalid7, ovr8, ovr7, busy8, busy7;

  int          n_cmp = 0;
  int          n_err = 0;
  int          word_cnt, rise_cyc, ovr_cnt, busy_last;
  bit          busy_seen;
  logic [8:0]  cap_data;
  logic [2:0]  cap_user;

  always #5 clk = ~clk;

  axis_uart_rx_ovs #(.DATA_WIDTH(8), .OVERSAMPLE(16), .DIVIDER_WIDTH(16)) u_dut8 (
    .clk_i(clk), .rstn_i(rstn), .rx_i(rx8), .clk_divider_i(clk_div),
    .parity_odd_i(par_odd), .parity_even_i(par_even), .two_stop_i(two_stop),
    .m_axis_tdata(tdata8), .m_axis_tuser(tuser8), .m_axis_tvalid(tvalid8),
    .m_axis_tready(tready8), .overrun_o(ovr8), .busy_o(busy8)
  );

  axis_uart_rx_ovs #(.DATA_WIDTH(7), .OVERSAMPLE(16), .DIVIDER_WIDTH(16)) u_dut7 (
    .clk_i(clk), .rstn_i(rstn), .rx_i(rx7), .clk_divider_i(clk_div),
    .parity_odd_i(par_odd), .parity_even_i(par_even), .two_stop_i(two_stop),
    .m_axis_tdata(tdata7), .m_axis_tuser(tuser7), .m_axis_tvalid(tvalid7),
    .m_axis_tready(tready7), .overrun_o(ovr7), .busy_o(busy7)
  );

  // 8N1 frame, LSB of the vector is the first bit on the line
  function automatic logic [31:0] frame8(input logic [7:0] d);
    return {22'h0, 1'b1, d, 1'b0};
  endfunction

  // 8-bit frame with a parity bit and one stop bit
  function automatic logic [31:0] frame8p(input logic [7:0] d, input logic p);
    return {21'h0, 1'b1, p, d, 1'b0};
  endfunction

  task automatic clear_obs();
    word_cnt  = 0;
    rise_cyc  = -1;
    ovr_cnt   = 0;
    busy_last = -1;
    busy_seen = 1'b0;
    cap_data  = 9'h1FF;
    cap_user  = 3'b111;
  endtask

  // Drive nbits frame bits then tail idle cycles; optionally invert the line for
  // noise_len cycles from noise_c. Observes the selected DUT after every edge.
  task automatic drive_frame(input logic [31:0] bits, input int nbits, input bit to7,
                             input int tail, input int noise_c, input int noise_len);
    logic line, v, prev_v;
    prev_v = to7 ? tvalid7 : tvalid8;
    for (int c = 0; c < nbits * BIT_CLKS + tail; c++) begin
      line = (c < nbits * BIT_CLKS) ? bits[c / BIT_CLKS] : 1'b1;
      if (noise_c >= 0 && c >= noise_c && c < noise_c + noise_len) line = ~line;
      if (to7) rx7 = line;
      else     rx8 = line;
      @(posedge clk);
      #1;
      v = to7 ? tvalid7 : tvalid8;
      if (v && (to7 ? tready7 : tready8)) begin
        word_cnt++;
        cap_data = to7 ? 9'(tdata7) : 9'(tdata8);
        cap_user = to7 ? tuser7 : tuser8;
      end
      if (v && !prev_v && rise_cyc < 0) rise_cyc = c + 1;
      prev_v = v;
      if (to7 ? ovr7 : ovr8) ovr_cnt++;
      if (to7 ? busy7 : busy8) begin
        busy_seen = 1'b1;
        busy_last = c + 1;
      end
    end
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    n_cmp++; if (tvalid8 !== 1'b0) begin n_err++; $display("[TB] FAIL reset_tvalid got=%b exp=0", tvalid8); end
    n_cmp++; if (tdata8 !== 8'h00) begin n_err++; $display("[TB] FAIL reset_tdata got=%h exp=00", tdata8); end
    n_cmp++; if (tuser8 !== 3'b000) begin n_err++; $display("[TB] FAIL reset_tuser got=%b exp=000", tuser8); end
    n_cmp++; if (ovr8 !== 1'b0) begin n_err++; $display("[TB] FAIL reset_overrun got=%b exp=0", ovr8); end
    n_cmp++; if (busy8 !== 1'b0) begin n_err++; $display("[TB] FAIL reset_busy got=%b exp=0", busy8); end
    n_cmp++; if (tvalid7 !== 1'b0) begin n_err++; $display("[TB] FAIL reset_tvalid7 got=%b exp=0", tvalid7); end
  endtask

  // Start edge seen 3 edges after the line falls, first tick 4 edges later,
  // stop decision at sample 9*16+9 -> edge 7+4*153 = 619, OUT, tvalid after edge 620
  task automatic test_8n1();
    $display("[TB] test_8n1");
    tready8 = 1'b1;
    clear_obs();
    drive_frame(frame8(8'hA5), 10, 1'b0, 40, -1, 0);
    n_cmp++; if (word_cnt != 1) begin n_err++; $display("[TB] FAIL 8n1_words got=%0d exp=1", word_cnt); end
    n_cmp++; if (cap_data !== 9'h0A5) begin n_err++; $display("[TB] FAIL 8n1_data got=%h exp=0a5", cap_data); end
    n_cmp++; if (cap_user !== 3'b000) begin n_err++; $display("[TB] FAIL 8n1_user got=%b exp=000", cap_user); end
    n_cmp++; if (rise_cyc != 620) begin n_err++; $display("[TB] FAIL 8n1_latency got=%0d exp=620", rise_cyc); end
  endtask

  task automatic test_start_glitch();
    $display("[TB] test_start_glitch");
    clear_obs();
    drive_frame(32'hFFFF_FFFF, 1, 1'b0, 40, 0, 12);
    n_cmp++; if (!busy_seen) begin n_err++; $display("[TB] FAIL glitch_busy_seen got=0 exp=1"); end
    n_cmp++; if (!(busy_last > 0 && busy_last < BIT_CLKS)) begin
      n_err++; $display("[TB] FAIL glitch_busy_end got=%0d exp=<%0d", busy_last, BIT_CLKS);
    end
    n_cmp++; if (rise_cyc != -1) begin n_err++; $display("[TB] FAIL glitch_tvalid got=%0d exp=-1", rise_cyc); end
  endtask

  // Noise covers only sample 8 of data bit 2 (frame bit 3, line cycle 228)
  task automatic test_majority();
    $display("[TB] test_majority");
    clear_obs();
    drive_frame(frame8(8'h3C), 10, 1'b0, 40, 226, 4);
    n_cmp++; if (cap_data !== 9'h03C) begin n_err++; $display("[TB] FAIL majority_data got=%h exp=03c", cap_data); end
    n_cmp++; if (cap_user !== 3'b000) begin n_err++; $display("[TB] FAIL majority_user got=%b exp=000", cap_user); end
  endtask

  // Both parity enables set: odd wins, 0xA5 has four ones so the odd bit is 1
  task automatic test_parity_odd_wins();
    $display("[TB] test_parity_odd_wins");
    par_odd  = 1'b1;
    par_even = 1'b1;
    clear_obs();
    drive_frame(frame8p(8'hA5, 1'b1), 11, 1'b0, 40, -1, 0);
    par_odd  = 1'b0;
    par_even = 1'b0;
    n_cmp++; if (cap_data !== 9'h0A5) begin n_err++; $display("[TB] FAIL oddpar_data got=%h exp=0a5", cap_data); end
    n_cmp++; if (cap_user !== 3'b000) begin n_err++; $display("[TB] FAIL oddpar_user got=%b exp=000", cap_user); end
  endtask

  // 7E2: 0x55 has four ones, so the even parity bit is 0
  task automatic test_7e2_errors();
    logic [31:0] f;
    $display("[TB] test_7e2_errors");
    par_even = 1'b1;
    two_stop = 1'b1;
    tready7  = 1'b1;
    clear_obs();
    f = {21'h0, 1'b1, 1'b1, 1'b1, 7'h55, 1'b0};
    drive_frame(f, 11, 1'b1, 40, -1, 0);
    n_cmp++; if (cap_data !== 9'h055) begin n_err++; $display("[TB] FAIL 7e2_par_data got=%h exp=055", cap_data); end
    n_cmp++; if (cap_user !== 3'b001) begin n_err++; $display("[TB] FAIL 7e2_par_user got=%b exp=001", cap_user); end
    clear_obs();
    f = {21'h0, 1'b0, 1'b1, 1'b0, 7'h55, 1'b0};
    drive_frame(f, 11, 1'b1, 40, -1, 0);
    n_cmp++; if (cap_data !== 9'h055) begin n_err++; $display("[TB] FAIL 7e2_stop_data got=%h exp=055", cap_data); end
    n_cmp++; if (cap_user !== 3'b010) begin n_err++; $display("[TB] FAIL 7e2_stop_user got=%b exp=010", cap_user); end
    n_cmp++; if (word_cnt != 1) begin n_err++; $display("[TB] FAIL 7e2_words got=%0d exp=1", word_cnt); end
    par_even = 1'b0;
    two_stop = 1'b0;
  endtask

  task automatic test_break();
    logic [2:0] exp_user;
    logic       exp_busy;
`ifdef AXIS_UART_RX_BREAK_DETECT_EN
    exp_user = 3'b110;
    exp_busy = 1'b1;
`else
    exp_user = 3'b010;
    exp_busy = 1'b0;
`endif
    $display("[TB] test_break");
    tready8 = 1'b1;
    clear_obs();
    drive_frame(32'h0, 20, 1'b0, 0, -1, 0);
    n_cmp++; if (busy8 !== exp_busy) begin n_err++; $display("[TB] FAIL break_busy got=%b exp=%b", busy8, exp_busy); end
    drive_frame(32'hFFFF_FFFF, 0, 1'b0, 200, -1, 0);
    n_cmp++; if (word_cnt != 1) begin n_err++; $display("[TB] FAIL break_words got=%0d exp=1", word_cnt); end
    n_cmp++; if (cap_data !== 9'h000) begin n_err++; $display("[TB] FAIL break_data got=%h exp=000", cap_data); end
    n_cmp++; if (cap_user !== exp_user) begin n_err++; $display("[TB] FAIL break_user got=%b exp=%b", cap_user, exp_user); end
    drive_frame(frame8(8'h5A), 10, 1'b0, 40, -1, 0);
    n_cmp++; if (word_cnt != 2) begin n_err++; $display("[TB] FAIL after_break_words got=%0d exp=2", word_cnt); end
    n_cmp++; if (cap_data !== 9'h05A) begin n_err++; $display("[TB] FAIL after_break_data got=%h exp=05a", cap_data); end
  endtask

  task automatic test_overrun_and_reset();
    $display("[TB] test_overrun_and_reset");
    tready8 = 1'b0;
    clear_obs();
    drive_frame(frame8(8'h11), 10, 1'b0, 20, -1, 0);
    drive_frame(frame8(8'h22), 10, 1'b0, 20, -1, 0);
    n_cmp++; if (tvalid8 !== 1'b1) begin n_err++; $display("[TB] FAIL ovr_tvalid got=%b exp=1", tvalid8); end
    n_cmp++; if (tdata8 !== 8'h11) begin n_err++; $display("[TB] FAIL ovr_tdata got=%h exp=11", tdata8); end
    n_cmp++; if (tuser8 !== 3'b000) begin n_err++; $display("[TB] FAIL ovr_tuser got=%b exp=000", tuser8); end
    n_cmp++; if (ovr_cnt != 1) begin n_err++; $display("[TB] FAIL ovr_pulses got=%0d exp=1", ovr_cnt); end
    drive_frame(frame8(8'h33), 5, 1'b0, 0, -1, 0);
    n_cmp++; if (busy8 !== 1'b1) begin n_err++; $display("[TB] FAIL midframe_busy got=%b exp=1", busy8); end
    rstn = 1'b0;
    #1;
    n_cmp++; if (tvalid8 !== 1'b0) begin n_err++; $display("[TB] FAIL rst_tvalid got=%b exp=0", tvalid8); end
    n_cmp++; if (tdata8 !== 8'h00) begin n_err++; $display("[TB] FAIL rst_tdata got=%h exp=00", tdata8); end
    n_cmp++; if (tuser8 !== 3'b000) begin n_err++; $display("[TB] FAIL rst_tuser got=%b exp=000", tuser8); end
    n_cmp++; if (ovr8 !== 1'b0) begin n_err++; $display("[TB] FAIL rst_overrun got=%b exp=0", ovr8); end
    n_cmp++; if (busy8 !== 1'b0) begin n_err++; $display("[TB] FAIL rst_busy got=%b exp=0", busy8); end
    rx8 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rstn = 1'b1;
    clear_obs();
    drive_frame(32'hFFFF_FFFF, 0, 1'b0, 700, -1, 0);
    n_cmp++; if (rise_cyc != -1) begin n_err++; $display("[TB] FAIL rst_no_word got=%0d exp=-1", rise_cyc); end
  endtask

  // Safety net against a stuck simulation
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired got=timeout exp=finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    rstn     = 1'b0;
    rx8      = 1'b1;
    rx7      = 1'b1;
    clk_div  = 16'd4;
    par_odd  = 1'b0;
    par_even = 1'b0;
    two_stop = 1'b0;
    tready8  = 1'b0;
    tready7  = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    test_reset();
    rstn = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    test_8n1();
    test_start_glitch();
    test_majority();
    test_parity_odd_wins();
    test_7e2_errors();
    test_break();
    test_overrun_and_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
